// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB endpoint FIFO.
//   EP_W       - width of the endpoint number presented by the USB core
//   LEN_W      - width of the IN packet length field
//   tx_state_t - IN-side transmit state machine encoding
//   min_len    - unsigned minimum, used to clamp packet length to MAXPKT
package usb_pkg;

    localparam int EP_W  = 4;
    localparam int LEN_W = 12;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ARM,
        TX_SEND,
        TX_DONE
    } tx_state_t;

    function automatic logic [LEN_W-1:0] min_len(input logic [LEN_W-1:0] a,
                                                 input logic [LEN_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_fifo_ram.sv
// usb_fifo_ram: DEPTH x 8 storage, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module usb_fifo_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_ep_fifo.sv
// usb_ep_fifo: byte FIFO bridging one OUT endpoint (rx side) to one IN
// endpoint (tx side) of a USB device core.
//   clk, rst_n    - clock, asynchronous active-low reset
//   endpt         - endpoint currently addressed by the core
//   rxact, rxval  - OUT transaction active / rxdat valid
//   rxdat         - OUT data byte
//   rxrdy         - FIFO can accept a byte (registered)
//   txact, txpop  - IN transaction active / core consumed txdat
//   txval         - txdat holds a byte of the current packet
//   txcork        - nothing to send, core NAKs the IN token
//   txdat         - current IN byte (FIFO head)
//   txdat_len     - length of the current IN packet, held until next arm
//   level         - FIFO occupancy
//   ovf           - sticky overflow flag (byte arrived while full)
module usb_ep_fifo
    import usb_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int EP_OUT = 2,
    parameter int EP_IN  = 2,
    parameter int MAXPKT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [EP_W-1:0]          endpt,
    input  logic                     rxact,
    input  logic                     rxval,
    input  logic [7:0]               rxdat,
    output logic                     rxrdy,
    input  logic                     txact,
    input  logic                     txpop,
    output logic                     txval,
    output logic                     txcork,
    output logic [7:0]               txdat,
    output logic [LEN_W-1:0]         txdat_len,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [EP_W-1:0]  EP_OUT_ID = EP_W'(EP_OUT);
    localparam logic [EP_W-1:0]  EP_IN_ID  = EP_W'(EP_IN);
    localparam logic [LEN_W-1:0] MAXPKT_L  = LEN_W'(MAXPKT);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
    localparam logic [PW-1:0]    DEPTH_L   = PW'(DEPTH);

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    level_next;
    logic [LEN_W-1:0] remain;
    logic [LEN_W-1:0] arm_len;
    logic [7:0]       rd_data;
    logic             txact_q;
    logic             rx_hit;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             tx_start;
    tx_state_t        state;
    tx_state_t        state_next;

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty    = (wptr == rptr);
    assign level    = wptr - rptr;

    assign rx_hit   = rxact && rxval && (endpt == EP_OUT_ID);
    assign push     = rx_hit && !full;
    assign pop      = (state == TX_SEND) && txpop && (remain != '0);
    assign tx_start = txact && !txact_q && (endpt == EP_IN_ID);
    assign arm_len  = min_len(LEN_W'(level), MAXPKT_L);

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + PTR_ONE;
        end else if (pop && !push) begin
            level_next = level - PTR_ONE;
        end
    end

    usb_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr[AW-1:0]),
        .wdata (rxdat),
        .raddr (rptr[AW-1:0]),
        .rdata (rd_data)
    );

    // Pointers, flags and txact edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            ovf     <= 1'b0;
            rxrdy   <= 1'b1;
            txact_q <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            if (rx_hit && full) begin
                ovf <= 1'b1;
            end
            // Registered from next occupancy so rxrdy tracks the level
            // visible in the same cycle.
            rxrdy   <= (level_next != DEPTH_L);
            txact_q <= txact;
        end
    end

    // Tx state register plus packet length / remaining count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TX_IDLE;
            remain    <= '0;
            txdat_len <= '0;
        end else begin
            state <= state_next;
            if (state == TX_ARM) begin
                txdat_len <= arm_len;
                remain    <= arm_len;
            end else if (pop) begin
                remain <= remain - LEN_ONE;
            end
        end
    end

    always_comb begin
        state_next = state;
        txval      = 1'b0;
        txdat      = '0;
        txcork     = empty;
        case (state)
            TX_IDLE: begin
                if (tx_start) begin
                    state_next = TX_ARM;
                end
            end
            TX_ARM: begin
                state_next = (arm_len != '0) ? TX_SEND : TX_DONE;
            end
            TX_SEND: begin
                txval  = 1'b1;
                txdat  = rd_data;
                txcork = 1'b0;
                // An abort still honours a pop in the same cycle.
                if (!txact) begin
                    state_next = TX_IDLE;
                end else if (pop && (remain == LEN_ONE)) begin
                    state_next = TX_DONE;
                end
            end
            TX_DONE: begin
                if (!txact) begin
                    state_next = TX_IDLE;
                end
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_ep_fifo.sv
// tb_usb_ep_fifo: self-checking bench for usb_ep_fifo. A queue-based model
// tracks FIFO contents and IN packet progress; every falling edge the DUT
// outputs are compared against it. Directed sequences add literal checks.
module tb_usb_ep_fifo;

    localparam int DEPTH  = 64;
    localparam int MAXPKT = 48;
    localparam int EP     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  endpt = 4'd0;
    logic        rxact = 1'b0;
    logic        rxval = 1'b0;
    logic [7:0]  rxdat = 8'd0;
    logic        rxrdy;
    logic        txact = 1'b0;
    logic        txpop = 1'b0;
    logic        txval;
    logic        txcork;
    logic [7:0]  txdat;
    logic [11:0] txdat_len;
    logic [6:0]  level;
    logic        ovf;

    always #5 clk = ~clk;

    usb_ep_fifo #(
        .DEPTH  (DEPTH),
        .EP_OUT (EP),
        .EP_IN  (EP),
        .MAXPKT (MAXPKT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .endpt     (endpt),
        .rxact     (rxact),
        .rxval     (rxval),
        .rxdat     (rxdat),
        .rxrdy     (rxrdy),
        .txact     (txact),
        .txpop     (txpop),
        .txval     (txval),
        .txcork    (txcork),
        .txdat     (txdat),
        .txdat_len (txdat_len),
        .level     (level),
        .ovf       (ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned mq[$];
    int  m_phase = 0;   // 0 idle, 1 arm, 2 send, 3 done
    int  m_rem   = 0;
    int  m_len   = 0;
    bit  m_ovf   = 1'b0;
    bit  m_prev  = 1'b0;
    bit  m_hit, m_push, m_pop;
    int  m_avail;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_phase = 0;
            m_rem   = 0;
            m_len   = 0;
            m_ovf   = 1'b0;
            m_prev  = 1'b0;
        end else begin
            m_hit   = rxact && rxval && (int'(endpt) == EP);
            m_push  = m_hit && (mq.size() < DEPTH);
            m_pop   = (m_phase == 2) && txpop && (m_rem > 0);
            m_avail = mq.size();
            if (m_hit && !m_push) m_ovf = 1'b1;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(rxdat);
            case (m_phase)
                0: if (txact && !m_prev && int'(endpt) == EP) m_phase = 1;
                1: begin
                    m_len   = (m_avail < MAXPKT) ? m_avail : MAXPKT;
                    m_rem   = m_len;
                    m_phase = (m_len > 0) ? 2 : 3;
                end
                2: begin
                    if (m_pop) m_rem--;
                    if (!txact) m_phase = 0;
                    else if (m_pop && m_rem == 0) m_phase = 3;
                end
                default: if (!txact) m_phase = 0;
            endcase
            m_prev = txact;
        end
    end

    always @(negedge clk) begin
        chk("level",     int'(level),     mq.size());
        chk("rxrdy",     int'(rxrdy),     (mq.size() < DEPTH) ? 1 : 0);
        chk("ovf",       int'(ovf),       int'(m_ovf));
        chk("txval",     int'(txval),     (m_phase == 2) ? 1 : 0);
        chk("txcork",    int'(txcork),    (mq.size() == 0 && m_phase != 2) ? 1 : 0);
        chk("txdat_len", int'(txdat_len), m_len);
        chk("txdat",     int'(txdat),     (m_phase == 2 && mq.size() > 0) ? int'(mq[0]) : 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            endpt = 4'(EP);
            rxact = 1'b1;
            rxval = 1'b1;
            rxdat = 8'(first + i);
            tick();
        end
        rxact = 1'b0;
        rxval = 1'b0;
    endtask

    task automatic in_token(input int exp_len);
        endpt = 4'(EP);
        txact = 1'b1;
        tick();
        tick();
        chk("in_len",   int'(txdat_len), exp_len);
        chk("in_txval", int'(txval),     (exp_len > 0) ? 1 : 0);
    endtask

    task automatic end_in();
        txact = 1'b0;
        tick();
    endtask

    task automatic pop_pkt(input int n, input int first, input bit push_too,
                           input int pfirst, input int exp_lvl);
        for (int k = 0; k < n; k++) begin
            chk("pop_txval", int'(txval), 1);
            chk("pop_txdat", int'(txdat), (first + k) & 255);
            txpop = 1'b1;
            if (push_too) begin
                endpt = 4'(EP);
                rxact = 1'b1;
                rxval = 1'b1;
                rxdat = 8'(pfirst + k);
            end
            tick();
            if (push_too) chk("pp_level", int'(level), exp_lvl);
        end
        txpop = 1'b0;
        rxact = 1'b0;
        rxval = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        txact = 1'b0;
        txpop = 1'b0;
        rxact = 1'b0;
        rxval = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_level",  int'(level),     0);
        chk("rst_rxrdy",  int'(rxrdy),     1);
        chk("rst_txcork", int'(txcork),    1);
        chk("rst_txval",  int'(txval),     0);
        chk("rst_ovf",    int'(ovf),       0);
        chk("rst_len",    int'(txdat_len), 0);

        // Five bytes plus one on a foreign endpoint, then one IN packet.
        push_seq(5, 8'h11);
        endpt = 4'd3; rxact = 1'b1; rxval = 1'b1; rxdat = 8'hEE;
        tick();
        rxact = 1'b0; rxval = 1'b0;
        chk("five_level", int'(level), 5);
        in_token(5);
        pop_pkt(5, 8'h11, 1'b0, 0, 0);
        chk("five_txval_end", int'(txval), 0);
        chk("five_level_end", int'(level), 0);
        end_in();

        // IN token on an empty FIFO is corked.
        in_token(0);
        chk("empty_cork", int'(txcork), 1);
        tick();
        chk("empty_txval", int'(txval), 0);
        end_in();

        // Packet length clamped to MAXPKT, remainder in the next packet.
        push_seq(60, 0);
        in_token(48);
        pop_pkt(48, 0, 1'b0, 0, 0);
        chk("clamp_txval_end", int'(txval), 0);
        chk("clamp_level",     int'(level), 12);
        end_in();
        in_token(12);
        pop_pkt(12, 48, 1'b0, 0, 0);
        chk("rest_level", int'(level), 0);
        end_in();

        // Fill to full, one extra byte is dropped and flagged.
        push_seq(64, 8'h40);
        chk("full_rxrdy", int'(rxrdy), 0);
        chk("full_level", int'(level), 64);
        chk("full_ovf",   int'(ovf),   0);
        push_seq(1, 8'hFF);
        chk("ovf_set",    int'(ovf),   1);
        chk("ovf_level",  int'(level), 64);
        chk("ovf_rxrdy",  int'(rxrdy), 0);
        in_token(48);
        pop_pkt(48, 8'h40, 1'b0, 0, 0);
        chk("ovf_sticky", int'(ovf), 1);
        end_in();

        // Simultaneous push/pop at level 10, enough traffic to wrap pointers.
        do_reset();
        push_seq(10, 100);
        for (int p = 0; p < 7; p++) begin
            in_token(10);
            pop_pkt(10, 100 + 10 * p, 1'b1, 110 + 10 * p, 10);
            chk("wrap_txval_end", int'(txval), 0);
            end_in();
        end
        chk("wrap_level", int'(level), 10);

        // Reset in the middle of a packet.
        do_reset();
        push_seq(8, 8'hA0);
        in_token(8);
        pop_pkt(2, 8'hA0, 1'b0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txval",  int'(txval),  0);
        chk("mid_rst_txcork", int'(txcork), 1);
        chk("mid_rst_level",  int'(level),  0);
        txact = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        in_token(0);
        chk("post_rst_cork", int'(txcork), 1);
        end_in();

        // Randomised traffic checked by the model.
        for (int c = 0; c < 4000; c++) begin
            rxact = ($urandom_range(0, 3) != 0);
            rxval = $urandom_range(0, 1) == 1;
            endpt = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'(EP);
            rxdat = 8'($urandom);
            if (txact) txact = ($urandom_range(0, 19) != 0);
            else       txact = ($urandom_range(0, 7) == 0);
            txpop = ($urandom_range(0, 2) == 0);
            tick();
        end
        rxact = 1'b0;
        rxval = 1'b0;
        txact = 1'b0;
        txpop = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_ep_fifo.md
USB_EP_FIFO -- requirements
Module: usb_ep_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 64, the FIFO depth in bytes (power of 2, 4..1024).
REQ-002 SHALL have parameter EP_OUT, default 2, the OUT endpoint number accepted on the rx side.
REQ-003 SHALL have parameter EP_IN, default 2, the IN endpoint number served on the tx side.
REQ-004 SHALL have parameter MAXPKT, default 64, the maximum IN packet length in bytes (1..DEPTH).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 endpt  in  4  endpoint currently addressed by the USB core.
REQ-008 rxact  in  1  OUT transaction active.
REQ-009 rxval  in  1  rxdat valid this cycle.
REQ-010 rxdat  in  8  OUT data byte.
REQ-011 rxrdy  out  1  FIFO can accept a byte.
REQ-012 txact  in  1  IN transaction active.
REQ-013 txpop  in  1  core consumed the current txdat byte.
REQ-014 txval  out  1  txdat holds a valid byte of the current packet.
REQ-015 txcork  out  1  no data; core shall NAK the IN token.
REQ-016 txdat  out  8  current IN byte (FIFO head).
REQ-017 txdat_len  out  12  byte count of the current IN packet.
REQ-018 level  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-019 ovf  out  1  sticky: a byte arrived while full.

Function
REQ-020 Push SHALL occur when rxact && rxval && endpt==EP_OUT && level<DEPTH; the byte is written at wptr, which then increments modulo DEPTH.
REQ-021 rxrdy SHALL equal (level<DEPTH), registered.
REQ-022 A byte arriving when level==DEPTH SHALL be dropped, with ovf set until reset.
REQ-023 Tx FSM states: IDLE, ARM, SEND, DONE.
REQ-024 IDLE->ARM on the rising edge of txact with endpt==EP_IN (txact registered and edge-detected).
REQ-025 In ARM (one cycle), txdat_len SHALL latch min(level, MAXPKT), and the FSM SHALL go to SEND if that value is >0, else DONE.
REQ-026 txcork SHALL be 1 whenever level==0 and the FSM is not in SEND, otherwise 0.
REQ-027 In SEND, txval=1 and txdat=mem[rptr]; each txpop SHALL advance rptr and decrement the remaining packet count.
REQ-028 SEND->DONE when the remaining count reaches 0 after a pop; txval=0 from the following cycle.
REQ-029 DONE->IDLE when txact==0; deassertion of txact in SEND SHALL abort to IDLE, keeping bytes already popped consumed.
REQ-030 Simultaneous push and pop SHALL leave level unchanged; both pointers advance.
REQ-031 Pointers SHALL be $clog2(DEPTH)+1 bits wide; full = MSBs differ with equal low bits; empty = pointers equal.
REQ-032 txpop outside SEND, or with remaining count 0, SHALL be ignored.
REQ-033 txdat_len SHALL hold its value until the next ARM.

Reset
REQ-034 rst_n low SHALL asynchronously clear wptr, rptr, level, ovf, txval, txdat, txdat_len and the edge register, set the FSM to IDLE, and drive rxrdy=1 and txcork=1; memory contents are not reset.
REQ-035 Reset asserted mid-SEND SHALL discard the packet; after release the FIFO is empty.

Structure
REQ-036 The tx state enum and the endpoint-number width constant SHALL reside in package usb_pkg.
REQ-037 Storage SHALL be a sub-module usb_fifo_ram (1 write port, 1 async-read port, DEPTH x 8).

Verification
REQ-038 Push 5 bytes 0x11..0x15 on EP 2, then IN token -> txdat_len=5; txdat sequence 0x11..0x15; txval falls after the 5th pop; level=0.
REQ-039 Push 100 bytes (DEPTH 128) with MAXPKT=64 -> 1st IN len=64, 2nd IN len=36; bytes in order.
REQ-040 IN token with FIFO empty -> txcork=1, txval=0, FSM returns to IDLE when txact drops.
REQ-041 Push 65 bytes into DEPTH=64 -> rxrdy=0 after the 64th byte, 65th dropped, ovf=1, level=64.
REQ-042 Push and pop in the same cycle at level=10 -> level stays 10; pointer wrap across 63->0 preserves order.
REQ-043 Assert rst_n low during SEND after 2 of 8 pops -> txval=0, txcork=1, level=0 immediately; next IN token is corked.
